// File: rtl/act_replay_fifo.sv
// Activation FIFO that replays each popped entry on dout for a latched number of consumer beats.
// Back-to-back entries load on the final beat of the previous one, so the output has no bubble.
module act_replay_fifo #(
  parameter int WIDTH    = 8,
  parameter int LANES    = 4,
  parameter int DEPTH    = 16,
  parameter int PREC_W   = 4,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [LANES*WIDTH-1:0]     din,
  input  logic                       rd_en,
  input  logic [PREC_W-1:0]          precision,
  output logic [LANES*WIDTH-1:0]     dout,
  output logic                       dout_valid,
  output logic                       last,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       wr_drop
);

  localparam int DW = LANES * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_LV = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LV = LW'(AFULL_TH);

  typedef enum logic {IDLE, REPLAY} state_t;

  state_t              state_reg;
  logic [DW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [LW-1:0]       level_reg;
  logic [PREC_W-1:0]   rep_cnt_reg;
  logic [PREC_W-1:0]   prec_reg;
  logic [DW-1:0]       dout_reg;
  logic                valid_reg;
  logic                drop_reg;

  logic wr_acc;
  logic beat;
  logic pop;

  assign full        = (level_reg == DEPTH_LV);
  assign empty       = (level_reg == '0);
  assign almost_full = (level_reg >= AFULL_LV);
  assign level       = level_reg;
  assign dout        = dout_reg;
  assign dout_valid  = valid_reg;
  assign wr_drop     = drop_reg;

  // prec_reg is never 0 while valid_reg is high, so the subtraction cannot wrap there.
  assign last   = valid_reg && (rep_cnt_reg == prec_reg - PREC_W'(1));
  assign wr_acc = wr_en && !full;
  assign beat   = valid_reg && rd_en;
  // A pop happens either from IDLE or on the final beat of the current entry.
  assign pop    = rd_en && !empty && ((state_reg == IDLE) || last);

  // Storage array is deliberately left out of reset; stale words are never read before rewrite.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      rep_cnt_reg <= '0;
      prec_reg    <= '0;
      dout_reg    <= '0;
      valid_reg   <= 1'b0;
      drop_reg    <= 1'b0;
    end else begin
      drop_reg  <= wr_en && full;
      level_reg <= level_reg + LW'(wr_acc) - LW'(pop);
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        dout_reg    <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
        rep_cnt_reg <= '0;
        prec_reg    <= (precision == '0) ? PREC_W'(1) : precision;
        state_reg   <= REPLAY;
        valid_reg   <= 1'b1;
      end else if (beat) begin
        if (last) begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end else begin
          rep_cnt_reg <= rep_cnt_reg + PREC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_act_replay_fifo.sv
// Self-checking bench for act_replay_fifo: a queue-based reference model of storage plus a
// "beats remaining" view of the replayed entry, compared against the DUT after every clock.
module tb_act_replay_fifo;

  localparam int WIDTH    = 8;
  localparam int LANES    = 4;
  localparam int DEPTH    = 16;
  localparam int PREC_W   = 4;
  localparam int AFULL_TH = DEPTH - 2;
  localparam int DW       = LANES * WIDTH;
  localparam int LW       = $clog2(DEPTH) + 1;
  localparam int VW       = 6 + LW + DW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DW-1:0]     din = '0;
  logic [PREC_W-1:0] precision = '0;
  logic [DW-1:0]     dout;
  logic              dout_valid, last, full, empty, almost_full, wr_drop;
  logic [LW-1:0]     level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  act_replay_fifo #(
    .WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH), .PREC_W(PREC_W), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .precision(precision),
    .dout(dout), .dout_valid(dout_valid), .last(last), .full(full), .empty(empty),
    .almost_full(almost_full), .level(level), .wr_drop(wr_drop)
  );

  logic [VW-1:0] obs;
  assign obs = {dout_valid, last, full, empty, almost_full, wr_drop, level, dout};

  // Reference model: stored entries in a queue, current entry with beats still to show.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  int            m_left;
  logic          m_drop;

  function automatic void model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_left  = 0;
    m_drop  = 1'b0;
  endfunction

  function automatic void model_edge();
    logic was_full, was_empty, finishing, take;
    if (rst) begin
      model_reset();
      return;
    end
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    finishing = m_valid && (m_left == 1) && rd_en;
    take      = rd_en && !was_empty && (!m_valid || finishing);
    m_drop    = wr_en && was_full;
    if (take) begin
      m_dout  = q.pop_front();
      m_left  = (precision == '0) ? 1 : int'(precision);
      m_valid = 1'b1;
    end else if (m_valid && rd_en) begin
      m_left = m_left - 1;
      if (m_left == 0) m_valid = 1'b0;
    end
    if (wr_en && !was_full) q.push_back(din);
  endfunction

  function automatic logic [VW-1:0] expect_vec();
    int n;
    n = q.size();
    return {m_valid, (m_valid && m_left == 1), (n == DEPTH), (n == 0), (n >= AFULL_TH),
            m_drop, LW'(n), m_dout};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if (obs !== expect_vec()) begin
      fails++; $display("FAIL reset_state got %h want %h", obs, expect_vec());
    end
    repeat (2) tick();
    tests++;
    if ({dout_valid, empty, full, almost_full, wr_drop, level, dout} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {LW{1'b0}}, {DW{1'b0}}}) begin
      fails++; $display("FAIL reset_consts got v=%b e=%b f=%b lvl=%0d dout=%h", dout_valid, empty, full, level, dout);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (obs !== expect_vec()) begin
      fails++; $display("FAIL reset_release got %h want %h", obs, expect_vec());
    end
  endtask

  task automatic test_replay_basic();
    logic [DW:0] seen[$];
    logic [DW:0] exp_beats [6];
    exp_beats[0] = {1'b0, 32'h11223344};
    exp_beats[1] = {1'b0, 32'h11223344};
    exp_beats[2] = {1'b1, 32'h11223344};
    exp_beats[3] = {1'b0, 32'h55667788};
    exp_beats[4] = {1'b0, 32'h55667788};
    exp_beats[5] = {1'b1, 32'h55667788};
    precision = 4'd3;
    rd_en = 1'b0;
    wr_en = 1'b1;
    din = 32'h11223344; tick();
    din = 32'h55667788; tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      tests++;
      if (obs !== expect_vec()) begin
        fails++; $display("FAIL replay_basic cyc%0d got %h want %h", i, obs, expect_vec());
      end
      if (dout_valid) seen.push_back({last, dout});
    end
    rd_en = 1'b0;
    tests++;
    if (seen.size() != 6) begin
      fails++; $display("FAIL replay_beats count got %0d want 6", seen.size());
    end
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      tests++;
      if (seen[i] !== exp_beats[i]) begin
        fails++; $display("FAIL replay_beat%0d got %h want %h", i, seen[i], exp_beats[i]);
      end
    end
    tests++;
    if (dout_valid !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL replay_end got v=%b e=%b want v=0 e=1", dout_valid, empty);
    end
  endtask

  task automatic test_full_drop();
    logic [DW-1:0] wrote[$];
    logic [DW-1:0] got[$];
    rd_en = 1'b0;
    precision = 4'd1;
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      din = DW'($urandom);
      wrote.push_back(din);
      tick();
      tests++;
      if (obs !== expect_vec()) begin
        fails++; $display("FAIL fill cyc%0d got %h want %h", i, obs, expect_vec());
      end
    end
    din = ~wrote[0];
    tick();
    wr_en = 1'b0;
    tests++;
    if ({wr_drop, full, level} !== {1'b1, 1'b1, LW'(DEPTH)}) begin
      fails++; $display("FAIL drop_pulse got drop=%b full=%b lvl=%0d want 1 1 %0d", wr_drop, full, level, DEPTH);
    end
    tick();
    tests++;
    if ({wr_drop, level} !== {1'b0, LW'(DEPTH)}) begin
      fails++; $display("FAIL drop_once got drop=%b lvl=%0d want 0 %0d", wr_drop, level, DEPTH);
    end
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      tick();
      tests++;
      if (obs !== expect_vec()) begin
        fails++; $display("FAIL drain cyc%0d got %h want %h", i, obs, expect_vec());
      end
      if (dout_valid) got.push_back(dout);
    end
    rd_en = 1'b0;
    tests++;
    if (got.size() != DEPTH) begin
      fails++; $display("FAIL drain_count got %0d want %0d", got.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < got.size(); i++) begin
      tests++;
      if (got[i] !== wrote[i]) begin
        fails++; $display("FAIL drain_order idx%0d got %h want %h", i, got[i], wrote[i]);
      end
    end
  endtask

  task automatic test_prec_zero();
    int shown;
    shown = 0;
    precision = '0;
    rd_en = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) wr_en = 1'b0;
      din = DW'($urandom);
      tick();
      tests++;
      if (obs !== expect_vec()) begin
        fails++; $display("FAIL prec0 cyc%0d got %h want %h", i, obs, expect_vec());
      end
      if (dout_valid) begin
        shown++;
        tests++;
        if (last !== 1'b1) begin
          fails++; $display("FAIL prec0_last cyc%0d got %b want 1", i, last);
        end
      end
    end
    rd_en = 1'b0;
    tests++;
    if (shown != 4) begin
      fails++; $display("FAIL prec0_beats got %0d want 4", shown);
    end
  endtask

  task automatic test_rd_toggle();
    logic [4:0]    pat;
    logic [4:0]    exp_last;
    logic [DW-1:0] entry;
    pat = 5'b11001;
    exp_last = 5'b10000;
    precision = 4'd3;
    entry = DW'($urandom);
    din = entry;
    wr_en = 1'b1; tick();
    wr_en = 1'b0;
    rd_en = 1'b1; tick();
    precision = 4'd7;  // must not affect the entry already loaded
    for (int i = 0; i < 5; i++) begin
      rd_en = pat[i];
      tests++;
      if ({last, dout_valid, dout} !== {exp_last[i], 1'b1, entry}) begin
        fails++; $display("FAIL toggle cyc%0d got last=%b v=%b dout=%h want last=%b v=1 dout=%h", i, last, dout_valid, dout, exp_last[i], entry);
      end
      tick();
      tests++;
      if (obs !== expect_vec()) begin
        fails++; $display("FAIL toggle_model cyc%0d got %h want %h", i, obs, expect_vec());
      end
    end
    rd_en = 1'b0;
    tests++;
    if (dout_valid !== 1'b0) begin
      fails++; $display("FAIL toggle_idle got v=%b want 0", dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    rd_en = 1'b0;
    precision = 4'd1;
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = DW'($urandom); tick();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = DW'($urandom);
      tick();
      tests++;
      if (obs !== expect_vec() || level !== LW'(4)) begin
        fails++; $display("FAIL b2b cyc%0d got %h lvl=%0d want %h lvl=4", i, obs, level, expect_vec());
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (obs !== expect_vec()) begin
        fails++; $display("FAIL b2b_drain cyc%0d got %h want %h", i, obs, expect_vec());
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_wrap_random();
    int accepted;
    accepted = 0;
    for (int i = 0; i < 2000 && accepted < 3 * DEPTH; i++) begin
      wr_en = ($urandom_range(0, 99) < 60);
      rd_en = ($urandom_range(0, 99) < 70);
      precision = PREC_W'($urandom_range(0, 3));
      din = DW'($urandom);
      if (wr_en && q.size() < DEPTH) accepted++;
      tick();
      tests++;
      if (obs !== expect_vec()) begin
        fails++; $display("FAIL wrap cyc%0d got %h want %h", i, obs, expect_vec());
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 200 && (q.size() != 0 || m_valid); i++) begin
      tick();
      tests++;
      if (obs !== expect_vec()) begin
        fails++; $display("FAIL wrap_drain cyc%0d got %h want %h", i, obs, expect_vec());
      end
    end
    rd_en = 1'b0;
    tests++;
    if (dout_valid !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL wrap_end got v=%b e=%b want v=0 e=1", dout_valid, empty);
    end
  endtask

  task automatic test_reset_mid_replay();
    rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = DW'($urandom); tick();
    end
    wr_en = 1'b0;
    precision = 4'd3;
    rd_en = 1'b1;
    repeat (2) tick();
    tests++;
    if ({dout_valid, level} !== {1'b1, LW'(5)}) begin
      fails++; $display("FAIL midrst_pre got v=%b lvl=%0d want v=1 lvl=5", dout_valid, level);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if ({dout_valid, empty, level, dout} !== {1'b0, 1'b1, {LW{1'b0}}, {DW{1'b0}}}) begin
      fails++; $display("FAIL midrst_async got v=%b e=%b lvl=%0d dout=%h", dout_valid, empty, level, dout);
    end
    tick();
    rst = 1'b0;
    rd_en = 1'b0;
    tick();
    tests++;
    if (obs !== expect_vec()) begin
      fails++; $display("FAIL midrst_release got %h want %h", obs, expect_vec());
    end
    precision = 4'd2;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = DW'($urandom); tick();
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (obs !== expect_vec()) begin
        fails++; $display("FAIL midrst_fresh cyc%0d got %h want %h", i, obs, expect_vec());
      end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_replay_basic();
    test_full_drop();
    test_prec_zero();
    test_rd_toggle();
    test_back_to_back();
    test_wrap_random();
    test_reset_mid_replay();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/act_replay_fifo.md
ACT_REPLAY_FIFO -- requirements
Module: act_replay_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per lane element.
REQ-002 SHALL have parameter LANES, default 4, parallel activation lanes per entry.
REQ-003 SHALL have parameter DEPTH, default 16, entries; power of two, >= 2.
REQ-004 SHALL have parameter PREC_W, default 4, width of precision input.
REQ-005 SHALL have parameter AFULL_TH, default DEPTH-2, almost_full threshold in entries.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port din  input  LANES*WIDTH  write entry, lane 0 in LSBs.
REQ-010 SHALL have port rd_en  input  1  consumer advance/beat request.
REQ-011 SHALL have port precision  input  PREC_W  replay count per entry.
REQ-012 SHALL have port dout  output  LANES*WIDTH  current replayed entry.
REQ-013 SHALL have port dout_valid  output  1  dout holds a live entry.
REQ-014 SHALL have port last  output  1  current beat is final replay of entry.
REQ-015 SHALL have port full, empty, almost_full  output  1 each  storage status.
REQ-016 SHALL have port level  output  $clog2(DEPTH)+1  entries in storage, excluding output register.
REQ-017 SHALL have port wr_drop  output  1  one-cycle pulse: write refused.

Function
REQ-018 Write accepted when wr_en && !full; entry stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-019 wr_en && full SHALL discard din, leave state unchanged, pulse wr_drop next cycle.
REQ-020 full = (level==DEPTH); empty = (level==0); almost_full = (level>=AFULL_TH); all from registered level.
REQ-021 Read FSM states: IDLE (dout_valid=0), REPLAY (dout_valid=1).
REQ-022 Effective precision P = precision, except 0 treated as 1; P latched at each entry load; precision changes mid-entry ignored.
REQ-023 IDLE, rd_en && !empty: pop mem[rd_ptr] into dout, rd_ptr increments, rep_cnt<=0, go REPLAY; dout_valid high next cycle.
REQ-024 Beat = cycle with dout_valid && rd_en; each beat increments rep_cnt; rd_en low in REPLAY holds dout and rep_cnt.
REQ-025 last = dout_valid && (rep_cnt==P-1), combinational from registers.
REQ-026 Beat with last: if !empty, pop next entry same edge (no bubble), rep_cnt<=0, stay REPLAY; if empty, go IDLE, dout keeps old value.
REQ-027 Simultaneous accepted write and pop: both SHALL occur, level unchanged.
REQ-028 Write into empty FIFO SHALL be visible to pop no earlier than the following cycle.
REQ-029 Pointers wrap modulo DEPTH without loss; level never exceeds DEPTH or underflows.
REQ-030 Latency: write at edge N, IDLE rd_en at edge N+1, dout_valid/dout at edge N+2.

Reset
REQ-031 rst high SHALL immediately force: pointers, level, rep_cnt, latched P = 0; state IDLE; dout=0; dout_valid=0; wr_drop=0; empty=1, full=0, almost_full=0.
REQ-032 Reset mid-replay SHALL abandon the entry; stored memory contents need not be cleared and are never read before rewrite.
REQ-033 Operation resumes on first rising clk edge after rst deasserts.

Verification
REQ-034 Write 0x11223344, 0x55667788, precision=3, rd_en held high -> dout 0x11223344 for 3 beats (last on 3rd), then 0x55667788 3 beats with no bubble, then dout_valid=0, empty=1.
REQ-035 Write DEPTH entries, one more write -> full=1, wr_drop pulses once, level=DEPTH, extra entry never appears.
REQ-036 precision=0 -> each entry shown exactly 1 beat, last high every beat.
REQ-037 rd_en toggled 1,0,0,1,1 with P=3 -> entry held across low cycles, last on 5th cycle only.
REQ-038 level=4 steady, write+pop same cycle -> level stays 4; wrap pointers over 3*DEPTH entries, data order preserved.
REQ-039 Assert rst during replay with level=5 -> next cycle dout=0, dout_valid=0, level=0, empty=1; fresh writes read back correctly.
